router_input_requester: RTL and testbench

Per-input-port initiator for the 16x16 router's output arbitration. It takes packets from one input port's flit stream and decodes the destination from the header flit. It then raises a request toward the selected output's arbiter, waits for that arbiter's grant, and forwards the packet. It holds the request for the whole packet and drops it after end-of-packet. One instance sits in front of each input port. Its `req` bit i drives bit p of output i's arbiter `request` vector, and its `gnt` bit i is taken from bit p of that arbiter's `grant`.

---
 rtl/router_pkg.sv | 17 +
 rtl/router_input_requester.sv | 131 +++++++++++++
 tb/tb_router_input_requester.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared router constants and types.
// Output port count, port id and requester FSM state encoding.
package router_pkg;

  localparam int N_PORTS = 16;
  localparam int DEST_W  = $clog2(N_PORTS);

  typedef logic [DEST_W-1:0] port_id_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DROP
  } req_state_t;

endpackage

// File: rtl/router_input_requester.sv
// router_input_requester: per-input initiator for output arbitration.
// Decodes header dest, requests the output arbiter, forwards the packet.
module router_input_requester #(
  parameter int N_PORTS = router_pkg::N_PORTS,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_sop,
  input  logic               in_eop,
  output logic               in_ready,
  output logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] gnt,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_eop,
  input  logic               out_ready,
  output logic               busy,
  output logic               err_len,
  output logic               drop
);

  import router_pkg::*;

  localparam int PORT_W = $clog2(N_PORTS);
  localparam int LEN_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [PORT_W:0]  PORT_LIM = (PORT_W + 1)'(N_PORTS);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);

  req_state_t        state;
  logic [PORT_W-1:0] dest_q;
  logic [LEN_W-1:0]  len_q;
  logic [PORT_W-1:0] hdr_dest;
  logic              dest_ok;
  logic              gnt_sel;
  logic              len_last;
  logic              xfer;

  assign hdr_dest = in_data[PORT_W-1:0];
  assign dest_ok  = {1'b0, hdr_dest} < PORT_LIM;
  assign gnt_sel  = gnt[dest_q];
  assign len_last = (len_q == LEN_LAST);
  assign xfer     = in_valid & in_ready;
  assign out_data = in_data;

  // Handshake steering: flits pass through only while granted in XFER
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_eop   = 1'b0;
    unique case (state)
      IDLE: in_ready = in_valid & ~in_sop;
      REQ:  in_ready = 1'b0;
      XFER: begin
        in_ready  = out_ready & gnt_sel;
        out_valid = in_valid & gnt_sel;
        out_eop   = in_eop | len_last;
      end
      DROP: in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // FSM with request register, length counter and status pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      req     <= '0;
      dest_q  <= '0;
      len_q   <= '0;
      busy    <= 1'b0;
      err_len <= 1'b0;
      drop    <= 1'b0;
    end else begin
      err_len <= 1'b0;
      drop    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid & in_sop) begin
            busy <= 1'b1;
            if (dest_ok) begin
              dest_q <= hdr_dest;
              req    <= N_PORTS'(1) << hdr_dest;
              state  <= REQ;
            end else begin
              state <= DROP;
            end
          end else if (in_valid) begin
            drop <= 1'b1;
          end
        end
        REQ: begin
          if (gnt_sel) begin
            len_q <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          if (xfer) begin
            len_q <= len_q + 1'b1;
            if (in_eop | len_last) begin
              state   <= IDLE;
              req     <= '0;
              busy    <= 1'b0;
              err_len <= ~in_eop;
            end
          end
        end
        DROP: begin
          if (in_valid) begin
            drop <= 1'b1;
            if (in_eop) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          req   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_input_requester.sv
// tb_router_input_requester: directed bench for router_input_requester.
// Instance a: 16 ports, MAX_LEN 64. Instance b: 12 ports, MAX_LEN 4.
module tb_router_input_requester;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic        out_ready;

  logic [15:0] req_a, gnt_a;
  logic        in_ready_a, out_valid_a, out_eop_a;
  logic        busy_a, err_len_a, drop_a;
  logic [31:0] out_data_a;

  logic [11:0] req_b, gnt_b;
  logic        in_ready_b, out_valid_b, out_eop_b;
  logic        busy_b, err_len_b, drop_b;
  logic [31:0] out_data_b;

  logic        gmask;
  logic [15:0] gextra;
  int          sel;

  logic [15:0] c_req;
  logic        c_rdy, c_ov, c_oe, c_busy, c_err, c_drop;
  logic [31:0] c_od;

  int checks = 0;
  int errors = 0;

  logic [15:0] req_log[$];
  logic        rdy_log[$];
  logic        busy_log[$];
  logic [31:0] obs_data[$];
  logic        obs_eop[$];
  int          obs_k[$];
  int          drop_k[$];
  int          err_k[$];
  bit          timed_out;

  always #5 clk = ~clk;

  always_comb gnt_a = (req_a & {16{gmask}}) | gextra;
  always_comb gnt_b = (req_b & {12{gmask}}) | gextra[11:0];

  always_comb begin
    if (sel == 1) begin
      c_req  = {4'b0, req_b};
      c_rdy  = in_ready_b;
      c_ov   = out_valid_b;
      c_oe   = out_eop_b;
      c_od   = out_data_b;
      c_busy = busy_b;
      c_err  = err_len_b;
      c_drop = drop_b;
    end else begin
      c_req  = req_a;
      c_rdy  = in_ready_a;
      c_ov   = out_valid_a;
      c_oe   = out_eop_a;
      c_od   = out_data_a;
      c_busy = busy_a;
      c_err  = err_len_a;
      c_drop = drop_a;
    end
  end

  router_input_requester #(
    .N_PORTS(16), .DATA_W(32), .MAX_LEN(64)
  ) dut_a (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready_a), .req(req_a), .gnt(gnt_a),
    .out_valid(out_valid_a), .out_data(out_data_a),
    .out_eop(out_eop_a), .out_ready(out_ready),
    .busy(busy_a), .err_len(err_len_a), .drop(drop_a)
  );

  router_input_requester #(
    .N_PORTS(12), .DATA_W(32), .MAX_LEN(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready_b), .req(req_b), .gnt(gnt_b),
    .out_valid(out_valid_b), .out_data(out_data_b),
    .out_eop(out_eop_b), .out_ready(out_ready),
    .busy(busy_b), .err_len(err_len_b), .drop(drop_b)
  );

  function automatic logic [31:0] flit_val(input int dest, input int i);
    if (i == 0) return 32'(dest);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    gmask     = 1'b1;
    gextra    = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Presents one packet, follows the selected DUT's handshake, logs per cycle.
  task automatic run_pkt(input int n, input int dest, input bit hdr_sop,
                         input int hold, input int gap_after,
                         input int gap_len, input int budget);
    int idx, fwd, gap_k0, tail;
    idx = 0; fwd = 0; gap_k0 = -1; tail = 0; timed_out = 0;
    req_log.delete(); rdy_log.delete(); busy_log.delete();
    obs_data.delete(); obs_eop.delete(); obs_k.delete();
    drop_k.delete(); err_k.delete();
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      gmask = !((k < hold) ||
                (gap_k0 >= 0 && k >= gap_k0 && k < gap_k0 + gap_len));
      if (idx < n) begin
        in_valid = 1'b1;
        in_data  = flit_val(dest, idx);
        in_sop   = hdr_sop && (idx == 0);
        in_eop   = (idx == n - 1);
      end else begin
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = '0;
      end
      @(negedge clk);
      req_log.push_back(c_req);
      rdy_log.push_back(c_rdy);
      busy_log.push_back(c_busy);
      if (c_ov === 1'b1 && out_ready) begin
        obs_data.push_back(c_od);
        obs_eop.push_back(c_oe);
        obs_k.push_back(k);
        fwd++;
        if (fwd == gap_after && gap_k0 < 0) gap_k0 = k + 1;
      end
      if (c_drop === 1'b1) drop_k.push_back(k);
      if (c_err === 1'b1) err_k.push_back(k);
      if (in_valid && c_rdy === 1'b1) idx++;
      if (idx == n) begin
        tail++;
        if (tail > 4) break;
      end
    end
    if (idx < n) timed_out = 1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({req_a, busy_a, err_len_a, drop_a, out_valid_a, in_ready_a} !== 22'h0) begin
      errors++;
      $display("FAIL reset_a: req=%h busy=%b err=%b drop=%b ov=%b rdy=%b, wanted all 0",
               req_a, busy_a, err_len_a, drop_a, out_valid_a, in_ready_a);
    end
    checks++;
    if ({req_b, busy_b, err_len_b, drop_b, out_valid_b, in_ready_b} !== 18'h0) begin
      errors++;
      $display("FAIL reset_b: req=%h busy=%b err=%b drop=%b ov=%b rdy=%b, wanted all 0",
               req_b, busy_b, err_len_b, drop_b, out_valid_b, in_ready_b);
    end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    sel = 0;
    run_pkt(3, 5, 1'b1, 0, 0, 0, 40);
    checks++;
    if (timed_out) begin
      errors++; $display("FAIL basic_timeout: packet not consumed, wanted completion");
    end
    checks++;
    if (req_log[0] !== 16'h0000) begin
      errors++; $display("FAIL basic_req_early: got %h, wanted 0000", req_log[0]);
    end
    checks++;
    if (req_log[1] !== 16'h0020) begin
      errors++; $display("FAIL basic_req: got %h, wanted 0020", req_log[1]);
    end
    checks++;
    if (obs_k.size() != 3 || obs_k[0] != 2) begin
      errors++;
      $display("FAIL basic_latency: count %0d first %0d, wanted 3 at 2",
               obs_k.size(), obs_k[0]);
    end
    ok = (obs_data.size() == 3);
    for (int i = 0; i < 3; i++) begin
      if (obs_data[i] !== flit_val(5, i) || obs_eop[i] !== (i == 2)) ok = 0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_flits: got %0d flits last eop %b, wanted 3 in order eop on last",
               obs_data.size(), obs_eop[2]);
    end
    checks++;
    if (req_log[5] !== 16'h0000 || busy_log[5] !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: req %h busy %b, wanted 0000 0",
               req_log[5], busy_log[5]);
    end
  endtask

  task automatic test_grant_hold();
    bit ok;
    do_reset();
    sel = 0;
    gextra = 16'h0010;
    run_pkt(3, 5, 1'b1, 10, 0, 0, 60);
    gextra = '0;
    ok = 1;
    for (int k = 1; k <= 10; k++) if (req_log[k] !== 16'h0020) ok = 0;
    checks++;
    if (!ok || timed_out) begin
      errors++; $display("FAIL hold_req: req not held at 0020 while waiting (to=%0d)", timed_out);
    end
    checks++;
    if (obs_k.size() != 3 || obs_k[0] != 11) begin
      errors++;
      $display("FAIL hold_start: count %0d first fwd at %0d, wanted 3 at 11",
               obs_k.size(), obs_k[0]);
    end
  endtask

  task automatic test_grant_gap();
    bit ok;
    do_reset();
    sel = 0;
    run_pkt(4, 5, 1'b1, 0, 1, 4, 60);
    ok = (obs_data.size() == 4) && !timed_out;
    for (int i = 0; i < 4; i++) begin
      if (obs_data[i] !== flit_val(5, i) || obs_eop[i] !== (i == 3)) ok = 0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL gap_flits: got %0d flits, wanted 4 in order, none lost or duplicated",
               obs_data.size());
    end
    checks++;
    if (obs_k[0] != 2 || obs_k[1] != 7 || obs_k[2] != 8 || obs_k[3] != 9) begin
      errors++;
      $display("FAIL gap_timing: fwd at %0d %0d %0d %0d, wanted 2 7 8 9",
               obs_k[0], obs_k[1], obs_k[2], obs_k[3]);
    end
    ok = 1;
    for (int k = 3; k <= 6; k++) if (rdy_log[k] !== 1'b0) ok = 0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL gap_ready: in_ready high during grant gap, wanted 0");
    end
    ok = 1;
    for (int k = 1; k <= 9; k++) if (req_log[k] !== 16'h0020) ok = 0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL gap_req: req changed during packet, wanted 0020");
    end
  endtask

  task automatic test_max_len();
    bit ok;
    do_reset();
    sel = 1;
    run_pkt(6, 5, 1'b1, 0, 0, 0, 60);
    ok = (obs_data.size() == 4) && !timed_out;
    for (int i = 0; i < 4; i++) begin
      if (obs_data[i] !== flit_val(5, i) || obs_eop[i] !== (i == 3)) ok = 0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL maxlen_flits: got %0d flits eop3=%b, wanted 4 with eop on 4th",
               obs_data.size(), obs_eop[3]);
    end
    checks++;
    if (err_k.size() != 1 || err_k[0] != 6) begin
      errors++;
      $display("FAIL maxlen_err: %0d pulses first at %0d, wanted 1 at 6",
               err_k.size(), err_k[0]);
    end
    checks++;
    if (drop_k.size() != 2 || drop_k[0] != 7 || drop_k[1] != 8) begin
      errors++;
      $display("FAIL maxlen_drop: %0d pulses, wanted 2 at 7 and 8", drop_k.size());
    end
    checks++;
    if (req_log[1] !== 16'h0020 || req_log[6] !== 16'h0000) begin
      errors++;
      $display("FAIL maxlen_req: req %h then %h, wanted 0020 then 0000",
               req_log[1], req_log[6]);
    end
  endtask

  task automatic test_stray();
    bit ok;
    do_reset();
    sel = 0;
    run_pkt(1, 7, 1'b0, 0, 0, 0, 20);
    checks++;
    if (rdy_log[0] !== 1'b1 || drop_k.size() != 1 || drop_k[0] != 1) begin
      errors++;
      $display("FAIL stray_drop: rdy %b drops %0d, wanted rdy 1 and one drop at 1",
               rdy_log[0], drop_k.size());
    end
    ok = 1;
    foreach (req_log[k]) if (req_log[k] !== 16'h0000 || busy_log[k] !== 1'b0) ok = 0;
    checks++;
    if (!ok || obs_data.size() != 0) begin
      errors++; $display("FAIL stray_req: req/busy/out_valid raised, wanted all 0");
    end
  endtask

  task automatic test_bad_dest();
    bit ok;
    do_reset();
    sel = 1;
    run_pkt(3, 13, 1'b1, 0, 0, 0, 30);
    checks++;
    if (rdy_log[0] !== 1'b0 || busy_log[1] !== 1'b1 || busy_log[4] !== 1'b0) begin
      errors++;
      $display("FAIL bad_dest_state: rdy0 %b busy1 %b busy4 %b, wanted 0 1 0",
               rdy_log[0], busy_log[1], busy_log[4]);
    end
    checks++;
    if (drop_k.size() != 3 || drop_k[0] != 2 || drop_k[2] != 4) begin
      errors++;
      $display("FAIL bad_dest_drop: %0d pulses, wanted 3 at 2..4", drop_k.size());
    end
    ok = !timed_out && (obs_data.size() == 0);
    foreach (req_log[k]) if (req_log[k] !== 16'h0000) ok = 0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bad_dest_req: req or out_valid raised, wanted none");
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    sel = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_data = flit_val(5, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== flit_val(5, 0)) begin
      errors++;
      $display("FAIL rst_mid_hdr: ov %b data %h, wanted 1 %h",
               out_valid_a, out_data_a, flit_val(5, 0));
    end
    @(posedge clk); #1;
    in_sop = 1'b0; in_data = flit_val(5, 1);
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_a !== 16'h0000 || busy_a !== 1'b0 || out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: req %h busy %b ov %b, wanted 0000 0 0",
               req_a, busy_a, out_valid_a);
    end
    run_pkt(3, 5, 1'b1, 0, 0, 0, 40);
    ok = (obs_data.size() == 3) && !timed_out;
    for (int i = 0; i < 3; i++) begin
      if (obs_data[i] !== flit_val(5, i) || obs_eop[i] !== (i == 2)) ok = 0;
    end
    checks++;
    if (!ok || req_log[req_log.size() - 1] !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_fresh: got %0d flits, wanted 3 complete and req released",
               obs_data.size());
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    gmask     = 1'b1;
    gextra    = '0;
    sel       = 0;
    test_reset();
    test_basic();
    test_grant_hold();
    test_grant_gap();
    test_max_len();
    test_stray();
    test_bad_dest();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
